sensor_uart_arbiter: RTL and testbench



---
 rtl/sensor_arb_pkg.sv | 23 ++
 rtl/sensor_arb_rr2.sv | 30 +++
 rtl/sensor_uart_arbiter.sv | 139 +++++++++++++
 tb/tb_sensor_uart_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sensor_arb_pkg.sv
// rtl/sensor_arb_pkg.sv - shared state/source types and header defaults for sensor_uart_arbiter
package sensor_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_ADS = 1'b0,
        SRC_MPR = 1'b1
    } src_t;

    localparam logic [7:0] HDR_ADS_DEFAULT = 8'hA5;
    localparam logic [7:0] HDR_MPR_DEFAULT = 8'h5A;

    function automatic int max_bytes(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sensor_arb_rr2.sv
// rtl/sensor_arb_rr2.sv - two-input round-robin grant with registered last-grant pointer
module sensor_arb_rr2
    import sensor_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_ads,
    input  logic req_mpr,
    input  logic accept,
    output logic gnt_ads,
    output logic gnt_mpr
);

    src_t last;

    // On a tie the source that did not win last time gets the grant.
    always_comb begin
        gnt_ads = req_ads & (~req_mpr | (last == SRC_MPR));
        gnt_mpr = req_mpr & ~gnt_ads;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= SRC_MPR;
        end else if (accept) begin
            last <= gnt_ads ? SRC_ADS : SRC_MPR;
        end
    end

endmodule

// File: rtl/sensor_uart_arbiter.sv
// rtl/sensor_uart_arbiter.sv - ADS1292/MPR121 frame arbiter and packet serializer toward UART TX
// SENSOR_ARB_CHKSUM_EN appends an XOR checksum byte after the payload.
module sensor_uart_arbiter
    import sensor_arb_pkg::*;
#(
    parameter int         ADS_BYTES = 6,
    parameter int         MPR_BYTES = 2,
    parameter logic [7:0] HDR_ADS   = HDR_ADS_DEFAULT,
    parameter logic [7:0] HDR_MPR   = HDR_MPR_DEFAULT
) (
    input  logic                   i_CLK,
    input  logic                   i_RST,
    input  logic                   i_ADS_VALID,
    input  logic [8*ADS_BYTES-1:0] i_ADS_DATA,
    output logic                   o_ADS_READY,
    input  logic                   i_MPR_VALID,
    input  logic [8*MPR_BYTES-1:0] i_MPR_DATA,
    output logic                   o_MPR_READY,
    output logic                   o_TX_VALID,
    output logic [7:0]             o_TX_BYTE,
    input  logic                   i_TX_READY,
    output logic                   o_BUSY
);

    localparam int MAX_BYTES = max_bytes(ADS_BYTES, MPR_BYTES);
    localparam int BUF_W     = 8 * MAX_BYTES;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);

    arb_state_t       state;
    logic [BUF_W-1:0] shift_buf;
    logic [BUF_W-1:0] next_buf;
    logic [CNT_W-1:0] byte_cnt;
    logic             gnt_ads;
    logic             gnt_mpr;
    logic             idle_open;
    logic             accept;
`ifdef SENSOR_ARB_CHKSUM_EN
    logic [7:0]       chk;
`endif

    sensor_arb_rr2 u_rr2 (
        .clk     (i_CLK),
        .rst     (i_RST),
        .req_ads (i_ADS_VALID),
        .req_mpr (i_MPR_VALID),
        .accept  (accept),
        .gnt_ads (gnt_ads),
        .gnt_mpr (gnt_mpr)
    );

    always_comb begin
        idle_open   = (state == ST_IDLE) & ~i_RST;
        o_ADS_READY = idle_open & gnt_ads;
        o_MPR_READY = idle_open & gnt_mpr;
        accept      = o_ADS_READY | o_MPR_READY;
        next_buf    = shift_buf << 8;
        o_BUSY      = (state != ST_IDLE);
    end

    // o_TX_BYTE always mirrors the byte on offer, so it doubles as the latched header.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state      <= ST_IDLE;
            o_TX_VALID <= 1'b0;
            o_TX_BYTE  <= 8'h00;
            shift_buf  <= '0;
            byte_cnt   <= '0;
`ifdef SENSOR_ARB_CHKSUM_EN
            chk        <= 8'h00;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_HDR;
                        o_TX_VALID <= 1'b1;
                        if (gnt_ads) begin
                            shift_buf <= BUF_W'(i_ADS_DATA) << (BUF_W - 8 * ADS_BYTES);
                            byte_cnt  <= CNT_W'(ADS_BYTES);
                            o_TX_BYTE <= HDR_ADS;
`ifdef SENSOR_ARB_CHKSUM_EN
                            chk       <= HDR_ADS;
`endif
                        end else begin
                            shift_buf <= BUF_W'(i_MPR_DATA) << (BUF_W - 8 * MPR_BYTES);
                            byte_cnt  <= CNT_W'(MPR_BYTES);
                            o_TX_BYTE <= HDR_MPR;
`ifdef SENSOR_ARB_CHKSUM_EN
                            chk       <= HDR_MPR;
`endif
                        end
                    end
                end
                ST_HDR: begin
                    if (i_TX_READY) begin
                        state     <= ST_PAYLOAD;
                        o_TX_BYTE <= shift_buf[BUF_W-1 -: 8];
                    end
                end
                ST_PAYLOAD: begin
                    if (i_TX_READY) begin
                        shift_buf <= next_buf;
                        byte_cnt  <= byte_cnt - CNT_W'(1);
`ifdef SENSOR_ARB_CHKSUM_EN
                        chk       <= chk ^ o_TX_BYTE;
`endif
                        if (byte_cnt == CNT_W'(1)) begin
`ifdef SENSOR_ARB_CHKSUM_EN
                            state      <= ST_CHK;
                            o_TX_BYTE  <= chk ^ o_TX_BYTE;
`else
                            state      <= ST_IDLE;
                            o_TX_VALID <= 1'b0;
                            o_TX_BYTE  <= 8'h00;
`endif
                        end else begin
                            o_TX_BYTE <= next_buf[BUF_W-1 -: 8];
                        end
                    end
                end
`ifdef SENSOR_ARB_CHKSUM_EN
                ST_CHK: begin
                    if (i_TX_READY) begin
                        state      <= ST_IDLE;
                        o_TX_VALID <= 1'b0;
                        o_TX_BYTE  <= 8'h00;
                    end
                end
`endif
                default: begin
                    state      <= ST_IDLE;
                    o_TX_VALID <= 1'b0;
                    o_TX_BYTE  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_uart_arbiter.sv
// tb/tb_sensor_uart_arbiter.sv - randomized scoreboard bench for sensor_uart_arbiter
module tb_sensor_uart_arbiter;

    localparam int         ADS_BYTES = 6;
    localparam int         MPR_BYTES = 2;
    localparam logic [7:0] HDR_ADS   = 8'hA5;
    localparam logic [7:0] HDR_MPR   = 8'h5A;
`ifdef SENSOR_ARB_CHKSUM_EN
    localparam int CHK_BYTES = 1;
`else
    localparam int CHK_BYTES = 0;
`endif
    localparam int PKT_ADS = 1 + ADS_BYTES + CHK_BYTES;
    localparam int NCYC    = 3000;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ads_valid;
    logic [8*ADS_BYTES-1:0] ads_data;
    logic                   ads_ready;
    logic                   mpr_valid;
    logic [8*MPR_BYTES-1:0] mpr_data;
    logic                   mpr_ready;
    logic                   tx_valid;
    logic [7:0]             tx_byte;
    logic                   tx_ready;
    logic                   busy;

    sensor_uart_arbiter #(
        .ADS_BYTES (ADS_BYTES),
        .MPR_BYTES (MPR_BYTES),
        .HDR_ADS   (HDR_ADS),
        .HDR_MPR   (HDR_MPR)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_ADS_VALID (ads_valid),
        .i_ADS_DATA  (ads_data),
        .o_ADS_READY (ads_ready),
        .i_MPR_VALID (mpr_valid),
        .i_MPR_DATA  (mpr_data),
        .o_MPR_READY (mpr_ready),
        .o_TX_VALID  (tx_valid),
        .o_TX_BYTE   (tx_byte),
        .i_TX_READY  (tx_ready),
        .o_BUSY      (busy)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    bit         last_mpr = 1'b1;
    bit         ads_taken = 1'b0;
    bit         mpr_taken = 1'b0;
    bit         cur_ads = 1'b0;
    bit         prev_stall = 1'b0;
    bit         prev_accept = 1'b0;
    bit         prev_rst = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic       e_ads;
    logic       e_mpr;
    logic [7:0] want;
    bit         mid_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference packet: header, payload MSB-first, then XOR of everything when enabled.
    task automatic push_pkt(input bit is_mpr, input logic [47:0] a, input logic [15:0] m);
        logic [7:0] x;
        logic [7:0] b;
        int         len;
        x   = is_mpr ? HDR_MPR : HDR_ADS;
        len = is_mpr ? MPR_BYTES : ADS_BYTES;
        exp_q.push_back(x);
        for (int i = 0; i < len; i++) begin
            b = is_mpr ? m[15 - 8*i -: 8] : a[47 - 8*i -: 8];
            exp_q.push_back(b);
            x = x ^ b;
        end
        if (CHK_BYTES != 0) exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (prev_rst) begin
            check("post_reset_tx_valid", 64'(tx_valid), 64'd0);
            check("post_reset_tx_byte", 64'(tx_byte), 64'd0);
            check("post_reset_busy", 64'(busy), 64'd0);
        end
        if (rst) begin
            check("ready_in_reset", 64'({ads_ready, mpr_ready}), 64'd0);
            exp_q.delete();
            last_mpr    = 1'b1;
            prev_stall  = 1'b0;
            prev_accept = 1'b0;
            prev_rst    = 1'b1;
        end else begin
            prev_rst = 1'b0;
            check("busy", 64'(busy), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e_ads = 1'b0;
                e_mpr = 1'b0;
            end else begin
                e_ads = ads_valid & (~mpr_valid | last_mpr);
                e_mpr = mpr_valid & ~e_ads;
            end
            check("ready_grant", 64'({ads_ready, mpr_ready}), 64'({e_ads, e_mpr}));
            if (prev_accept) check("hdr_latency", 64'(tx_valid), 64'd1);
            if (prev_stall) begin
                check("hold_valid", 64'(tx_valid), 64'd1);
                check("hold_byte", 64'(tx_byte), 64'(prev_byte));
            end
            if (tx_valid && tx_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL tx_unexpected: got byte 0x%0h, expected no byte (t=%0t)", tx_byte, $time);
                end else begin
                    want = exp_q.pop_front();
                    if (tx_byte !== want) begin
                        n_bad++;
                        $display("FAIL tx_byte: got 0x%0h, expected 0x%0h (t=%0t)", tx_byte, want, $time);
                    end
                end
            end
            prev_accept = 1'b0;
            if (ads_valid && ads_ready) begin
                push_pkt(1'b0, ads_data, 16'h0);
                last_mpr    = 1'b0;
                ads_taken   = 1'b1;
                cur_ads     = 1'b1;
                prev_accept = 1'b1;
            end else if (mpr_valid && mpr_ready) begin
                push_pkt(1'b1, 48'h0, mpr_data);
                last_mpr    = 1'b1;
                mpr_taken   = 1'b1;
                cur_ads     = 1'b0;
                prev_accept = 1'b1;
            end
            prev_stall = tx_valid & ~tx_ready;
            prev_byte  = tx_byte;
        end
    end

    task automatic drive_cycle(input bit gen_on, input bit force_ready);
        logic [63:0] r64;
        if (ads_taken) begin
            ads_taken = 1'b0;
            ads_valid = 1'b0;
        end
        if (mpr_taken) begin
            mpr_taken = 1'b0;
            mpr_valid = 1'b0;
        end
        if (gen_on && !ads_valid && $urandom_range(0, 2) != 0) begin
            r64       = {$urandom, $urandom};
            ads_data  = r64[47:0];
            ads_valid = 1'b1;
        end
        if (gen_on && !mpr_valid && $urandom_range(0, 2) != 0) begin
            mpr_data  = 16'($urandom_range(0, 4095));
            mpr_valid = 1'b1;
        end
        tx_ready = force_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        bit drained;
        rst       = 1'b1;
        ads_valid = 1'b1;
        ads_data  = 48'h112233445566;
        mpr_valid = 1'b1;
        mpr_data  = 16'h0ABC;
        tx_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            if (rst) rst = 1'b0;
            drive_cycle(cyc >= 30, cyc < 60);
            // Abort an ADS packet while its third payload byte is on offer.
            if (!mid_done && cyc > 300 && cur_ads && exp_q.size() == PKT_ADS - 3) begin
                rst      = 1'b1;
                mid_done = 1'b1;
            end
        end

        drained = 1'b0;
        for (int i = 0; i < 500 && !drained; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            drive_cycle(1'b0, 1'b1);
            if (!ads_valid && !mpr_valid && exp_q.size() == 0) drained = 1'b1;
        end
        check("drain_complete", 64'(drained), 64'd1);
        check("mid_packet_reset_hit", 64'(mid_done), 64'd1);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
